// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock parametrised FIFO with a registered occupancy
// count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through output; when it is
// undefined, d_out is a registered read port with one cycle of latency.
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        d_in,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        d_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    // Storage is deliberately left without reset; contents are don't-care after rst_n.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_evt;
    logic              udf_evt;

    // Array index is the pointer without its wrap bit.
    assign wr_addr = wr_ptr_q[ADDR_W-1:0];
    assign rd_addr = rd_ptr_q[ADDR_W-1:0];

    // Acceptance: a full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        wr_acc  = wr_en && (!full_q || rd_en);
        rd_acc  = rd_en && !empty_q;
        ovf_evt = wr_en && full_q && !rd_en;
        udf_evt = rd_en && empty_q;
    end

    // Next pointers, occupancy and flags; flags come from the next count so they never lag it.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        full_d         = full_q;
        empty_d        = empty_q;
        almost_full_d  = almost_full_q;
        almost_empty_d = almost_empty_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Pointer difference modulo 2*DEPTH equals count + wr_acc - rd_acc.
        count_d        = wr_ptr_d - rd_ptr_d;
        full_d         = (count_d == PTR_W'(DEPTH));
        empty_d        = (count_d == PTR_W'(0));
        almost_full_d  = (count_d >= PTR_W'(AF_LEVEL));
        almost_empty_d = (count_d <= PTR_W'(AE_LEVEL));

        // A new error event takes priority over a clear in the same cycle.
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        if (udf_evt) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Write port into the storage array.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= d_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented as soon as the FIFO is non-empty; rd_en pops it.
    always_comb begin
        d_out = '0;
        if (!empty_q) begin
            d_out = mem_q[rd_addr];
        end
    end
`else
    logic [DATA_W-1:0] d_out_q, d_out_d;

    // Registered read: head word is loaded on an accepted read, otherwise held.
    always_comb begin
        d_out_d = d_out_q;
        if (rd_acc) begin
            d_out_d = mem_q[rd_addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and randomised stimulus for fifo_sync_param,
// compared every cycle against a queue-based reference model.
// Honours FIFO_FWFT_EN the same way the design does.
module tb_fifo_sync_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [DATA_W-1:0] d_in;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] d_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [4:0]        count;
    logic              overflow;
    logic              underflow;

    fifo_sync_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .d_in        (d_in),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .d_out       (d_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state.
    logic [DATA_W-1:0] q_m [$];
    logic [DATA_W-1:0] dout_m;
    bit                ovf_m;
    bit                udf_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        if (q_m.size() == 0) return '0;
        return q_m[0];
`else
        return dout_m;
`endif
    endfunction

    task automatic check_all();
        int n;
        n = q_m.size();
        check_eq("count",        32'(count),        32'(n));
        check_eq("full",         32'(full),         32'(n == DEPTH));
        check_eq("empty",        32'(empty),        32'(n == 0));
        check_eq("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
        check_eq("overflow",     32'(overflow),     32'(ovf_m));
        check_eq("underflow",    32'(underflow),    32'(udf_m));
        check_eq("d_out",        32'(d_out),        32'(exp_dout()));
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, check after the edge.
    task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d, input bit clr);
        bit is_full;
        bit is_empty;
        bit w_ok;
        bit r_ok;
        wr_en   = w;
        rd_en   = r;
        d_in    = d;
        err_clr = clr;
        @(posedge clk);
        cyc++;
        is_full  = (q_m.size() == DEPTH);
        is_empty = (q_m.size() == 0);
        w_ok     = w && (!is_full || r);
        r_ok     = r && !is_empty;
        if (r_ok) dout_m = q_m.pop_front();
        if (w_ok) q_m.push_back(d);
        if (w && is_full && !r) ovf_m = 1'b1;
        else if (clr)           ovf_m = 1'b0;
        if (r && is_empty)      udf_m = 1'b1;
        else if (clr)           udf_m = 1'b0;
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges, released on a falling edge.
    task automatic do_reset();
        #2;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        q_m.delete();
        dout_m = '0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        d_in    = '0;
        dout_m  = '0;
        ovf_m   = 1'b0;
        udf_m   = 1'b0;
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x00..0x0F, then overflow attempts with 0xEE.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DATA_W'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Full with simultaneous read/write of 0x77, then drain everything.
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check_eq("full_rw_oldest", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
        check_eq("last_is_77", 32'(d_out), 32'h77);
`endif

        // Empty with simultaneous read/write: write taken, read rejected.
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check_eq("empty_rw_udf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        // Occupancy held at 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DATA_W'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Reset mid-stream, then first write after reset.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'($urandom), 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'hA5, 1'b0);
`ifdef FIFO_FWFT_EN
        check_eq("a5_visible", 32'(d_out), 32'hA5);
`endif
        step(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
        check_eq("a5_readback", 32'(d_out), 32'hA5);
`endif

`ifdef FIFO_FWFT_EN
        // Fall-through of a single word into an empty FIFO.
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        check_eq("fwft_3c", 32'(d_out), 32'h3C);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("fwft_pop_zero", 32'(d_out), 32'h0);
`endif

        // Random traffic with write-heavy, balanced and read-heavy phases.
        for (int ph = 0; ph < 3; ph++) begin
            int wp;
            wp = (ph == 0) ? 70 : (ph == 1) ? 50 : 30;
            for (int i = 0; i < 500; i++) begin
                if (ph == 1 && i == 250) do_reset();
                step(($urandom_range(99) < wp), ($urandom_range(99) < (100 - wp)),
                     DATA_W'($urandom), ($urandom_range(99) < 5));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO: single-clock buffer with configurable data width and depth, registered occupancy count, programmable almost-full/almost-empty thresholds and sticky error flags. A pass-through read is supported when the FIFO is full, and first-word-fall-through is a compile-time option. It is the general-purpose buffer between producer and consumer stages in the same clock domain.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  write request
- d_in  input  DATA_W  write data
- rd_en  input  1  read request
- err_clr  input  1  clears sticky overflow/underflow
- d_out  output  DATA_W  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; a write was rejected
- underflow  output  1  sticky; a read was rejected

## Operation
- Storage: DEPTH×DATA_W array, not reset. Write and read pointers are $clog2(DEPTH)+1 bits wide. The low bits index the array; the MSB is the wrap bit. Pointers wrap naturally modulo 2·DEPTH.
- Write acceptance: wr_acc = wr_en && (!full || rd_en). When the FIFO is full, a simultaneous read and write are both accepted and count is unchanged.
- Read acceptance: rd_acc = rd_en && !empty. When the FIFO is empty, a simultaneous read and write accept the write only; the read is rejected.
- count_next = count + wr_acc − rd_acc.
- All flags are registered from count_next, so each flag is exact in the same cycle that count updates (no lag).
- overflow is set when wr_en && full && !rd_en. underflow is set when rd_en && empty.
- Both error flags hold until err_clr. If err_clr and a new error event occur in the same cycle, the set wins.
- Standard mode: on rd_acc, d_out loads mem[rd_ptr] at the clock edge. Otherwise d_out holds its value.
- Reset (async assert, rst_n low):
  - pointers = 0, count = 0, d_out = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - overflow = 0, underflow = 0
- Reset mid-operation discards all contents; memory contents become don't-care.

## Timing
- Write accepted at edge N: count, empty, almost_* and full all update after edge N.
- Standard-mode read latency is 1 cycle: rd_en sampled at edge M, d_out valid after edge M.
- First write to an empty FIFO at edge N: earliest accepted read is at edge N+1, with data on d_out after edge N+1.
- Flags never assert combinationally from the inputs; all outputs are registered except d_out in FWFT mode.
- Reset deassertion: the first write can be accepted on the first rising edge after rst_n goes high.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - d_out is driven combinationally from mem[rd_ptr] whenever empty = 0, and is 0 when empty = 1.
  - rd_en acts as a pop/acknowledge of the word already on d_out.
  - A write into an empty FIFO at edge N makes the data visible on d_out after edge N, together with empty deasserting.
  - Acceptance rules and flag behaviour are unchanged.
- FIFO_FWFT_EN undefined: standard registered-read mode as described in Operation.

## Test plan
- Test parameters: DEPTH=16, DATA_W=8, AF_LEVEL=14, AE_LEVEL=2.
- Reset:
  - Stimulus: hold rst_n low mid-stream, then release.
  - Required: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, d_out=0. The first post-reset write of 0xA5 reads back as 0xA5.
- Fill and drain:
  - Stimulus: write 0x00..0x0F (16 writes), then read 16.
  - Required: almost_full rises with count 14, and full rises after the 16th write. Reads return 0x00..0x0F in order, and almost_empty rises when count reaches 2.
- Overflow:
  - Stimulus: full FIFO, wr_en=1 with d_in=0xEE, rd_en=0.
  - Required: overflow=1 and stays set, count stays 16, 0xEE is never read. One cycle of err_clr=1 then clears overflow to 0.
- Simultaneous read and write:
  - Stimulus: with the FIFO full, assert rd_en and wr_en (d_in=0x77) for 1 cycle.
  - Required: count stays 16, the oldest word is read, and 0x77 is read last.
  - Stimulus: with the FIFO empty, assert both for 1 cycle.
  - Required: underflow=1, count=1.
- Wrap-around:
  - Stimulus: 40 interleaved write/read pairs with occupancy held at 3.
  - Required: data order is preserved across pointer wrap; full and empty are never asserted.
- FWFT (FIFO_FWFT_EN defined):
  - Stimulus: write 0x3C into an empty FIFO.
  - Required: d_out=0x3C and empty=0 after the same edge. A rd_en pulse then sets empty=1 and d_out=0.
